// File: rtl/radio_pkg.sv
// -----------------------------------------------------------------------------
// radio_pkg
//   Definitions shared by the radio transmit framer: the framer state encoding,
//   the default PREAMBLE/SYNC bytes, the CRC-8 polynomial and a helper function
//   that advances a CRC-8 over one byte.
// -----------------------------------------------------------------------------
package radio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SYNC     = 3'd2,
        ST_LEN      = 3'd3,
        ST_PAYLOAD  = 3'd4,
        ST_CRC      = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    localparam logic [7:0] PREAMBLE_DEFAULT = 8'hAA;
    localparam logic [7:0] SYNC_DEFAULT     = 8'h7E;
    localparam logic [7:0] CRC8_POLY        = 8'h07;

    // CRC-8, MSB first, no reflection, no final XOR: fold one byte into crc.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// -----------------------------------------------------------------------------
// tx_byte_fifo
//   Synchronous byte FIFO with show-ahead output (dout is the head entry).
//   Ports:
//     clock, reset  - rising-edge clock, synchronous active-high reset
//     clear         - synchronous flush of all entries (takes priority)
//     push, din     - write din when not full
//     pop           - discard head entry when not empty
//     dout          - current head entry
//     count         - number of entries held
//     full, empty   - occupancy flags
//   Push and pop in the same cycle both take effect; count is unchanged.
// -----------------------------------------------------------------------------
module tx_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [7:0] count,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    count_q, count_d;
    logic          push_ok_s, pop_ok_s;

    assign full  = (count_q == 8'(DEPTH));
    assign empty = (count_q == 8'd0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next-state pointers and occupancy.
    always_comb begin
        push_ok_s = push && !full && !clear;
        pop_ok_s  = pop && !empty && !clear;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 8'd0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + 8'd1;
                2'b01:   count_d = count_q - 8'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (push_ok_s && !reset) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/radio_tx_framer.sv
// -----------------------------------------------------------------------------
// radio_tx_framer
//   Buffers payload bytes and, on flush, sends one frame
//   PREAMBLE, SYNC, LEN, payload[LEN], CRC-8 serially, MSB first, each bit held
//   CLKS_PER_BIT cycles.
//   Ports:
//     clock, reset          - rising-edge clock, synchronous active-high reset
//     enable                - radio enable; dropping it mid-frame aborts
//     radio_Tx, tx_data     - push strobe and payload byte
//     flush                 - start a frame with all buffered bytes
//     tx_serial             - serial data, idles 0
//     tx_busy               - frame in progress
//     fifo_count/fifo_full  - buffer occupancy
//     overflow              - sticky: push arrived while full
//     frame_done / aborted  - one-cycle completion / abort pulses
// -----------------------------------------------------------------------------
module radio_tx_framer
    import radio_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 16,
    parameter int         CLKS_PER_BIT = 4,
    parameter logic [7:0] PREAMBLE     = PREAMBLE_DEFAULT,
    parameter logic [7:0] SYNC         = SYNC_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       radio_Tx,
    input  logic [7:0] tx_data,
    input  logic       flush,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic [7:0] fifo_count,
    output logic       fifo_full,
    output logic       overflow,
    output logic       frame_done,
    output logic       aborted
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

    state_e        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    rem_q, rem_d;
    logic [7:0]    crc_q, crc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          aborted_q, aborted_d;
    logic          overflow_q, overflow_d;

    logic          sending_s, bit_end_s, byte_end_s;
    logic          fifo_push_s, fifo_pop_s, fifo_clear_s;
    logic [7:0]    fifo_dout_s, fifo_count_s;
    logic          fifo_full_s, fifo_empty_s;

    tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .clear (fifo_clear_s),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .din   (tx_data),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign tx_serial  = shift_q[7];
    assign tx_busy    = busy_q;
    assign fifo_count = fifo_count_s;
    assign fifo_full  = fifo_full_s;
    assign overflow   = overflow_q;
    assign frame_done = done_q;
    assign aborted    = aborted_q;

    // Next-state logic: FSM, bit timing, shift register, CRC and FIFO control.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        len_d        = len_q;
        rem_d        = rem_q;
        crc_d        = crc_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        fifo_pop_s   = 1'b0;
        fifo_clear_s = 1'b0;
        fifo_push_s  = radio_Tx && enable && !fifo_full_s;
        overflow_d   = overflow_q | (radio_Tx && enable && fifo_full_s);

        sending_s  = (state_q == ST_PREAMBLE) || (state_q == ST_SYNC) || (state_q == ST_LEN) ||
                     (state_q == ST_PAYLOAD) || (state_q == ST_CRC);
        bit_end_s  = (clk_cnt_q == CLK_LAST);
        byte_end_s = bit_end_s && (bit_cnt_q == 3'd7);

        // Both counters wrap together so the next byte starts on the very next cycle.
        if (sending_s) begin
            if (bit_end_s) begin
                clk_cnt_d = '0;
                bit_cnt_d = bit_cnt_q + 3'd1;
                shift_d   = {shift_q[6:0], 1'b0};
            end else begin
                clk_cnt_d = clk_cnt_q + CW'(1);
            end
        end else begin
            clk_cnt_d = '0;
            bit_cnt_d = 3'd0;
        end

        // At a byte boundary the shift register is reloaded instead of shifted.
        case (state_q)
            ST_IDLE: begin
                if (flush && enable && !fifo_empty_s) begin
                    state_d = ST_PREAMBLE;
                    shift_d = PREAMBLE;
                    len_d   = fifo_count_s;
                    rem_d   = fifo_count_s;
                    crc_d   = 8'd0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (byte_end_s) begin
                    state_d = ST_SYNC;
                    shift_d = SYNC;
                end else begin
                    state_d = ST_PREAMBLE;
                end
            end
            ST_SYNC: begin
                if (byte_end_s) begin
                    state_d = ST_LEN;
                    shift_d = len_q;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_LEN, ST_PAYLOAD: begin
                if (byte_end_s && (rem_q != 8'd0)) begin
                    state_d    = ST_PAYLOAD;
                    shift_d    = fifo_dout_s;
                    fifo_pop_s = 1'b1;
                    rem_d      = rem_q - 8'd1;
                    crc_d      = crc8_byte(crc_q, fifo_dout_s);
                end else if (byte_end_s) begin
                    state_d = ST_CRC;
                    shift_d = crc_q;
                end else begin
                    state_d = state_q;
                end
            end
            ST_CRC: begin
                if (byte_end_s) begin
                    state_d = ST_DONE;
                    shift_d = 8'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_CRC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                shift_d = 8'd0;
                busy_d  = 1'b0;
            end
        endcase

        // Losing enable mid-frame overrides everything above.
        if (sending_s && !enable) begin
            state_d      = ST_IDLE;
            shift_d      = 8'd0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            aborted_d    = 1'b1;
            fifo_pop_s   = 1'b0;
            fifo_clear_s = 1'b1;
            clk_cnt_d    = '0;
            bit_cnt_d    = 3'd0;
        end else begin
            aborted_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'd0;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= 3'd0;
            len_q      <= 8'd0;
            rem_q      <= 8'd0;
            crc_q      <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            crc_q      <= crc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            overflow_q <= overflow_d;
        end
    end

endmodule
